// File: rtl/stream_demux2_pkg.sv
// Shared types and constants for the two-way packet demultiplexer.
package stream_demux2_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W         = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register: a load wins over a drain in the same cycle,
// so a full slot that is both read and written stays full with the new beat.
module demux_out_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             last
);

    // data/last change only on load, so they hold while valid && !ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux2.sv
// Routes whole packets from one stream to out0 or out1, chosen by in_sel on the
// first beat. Optional per-output beat counters are built with STREAM_DEMUX2_CNT_EN.
//
// Handshake: a beat moves on any interface when its valid and ready are both high
// at a rising edge; valid, once raised, holds with stable data/last until taken.
module stream_demux2
    import stream_demux2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             in_sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    output logic             out0_last,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    output logic             out1_last,
    input  logic             out1_ready,
`ifdef STREAM_DEMUX2_CNT_EN
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
`endif
    output state_t           state
);

    state_t state_next;
    logic   target;
    logic   target_valid;
    logic   target_ready;
    logic   accept;
    logic   load0;
    logic   load1;

    // in_sel only matters while idle; a locked packet keeps its destination
    always_comb begin
        target = 1'b0;
        case (state)
            IDLE:    target = in_sel;
            LOCK0:   target = 1'b0;
            LOCK1:   target = 1'b1;
            default: target = 1'b0;
        endcase
    end

    assign target_valid = target ? out1_valid : out0_valid;
    assign target_ready = target ? out1_ready : out0_ready;
    assign in_ready     = !target_valid || target_ready;
    assign accept       = in_valid && in_ready;
    assign load0        = accept && !target;
    assign load1        = accept && target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !in_last) state_next = in_sel ? LOCK1 : LOCK0;
            end
            LOCK0, LOCK1: begin
                if (accept && in_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    demux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load0),
        .load_data (in_data),
        .load_last (in_last),
        .ready     (out0_ready),
        .valid     (out0_valid),
        .data      (out0_data),
        .last      (out0_last)
    );

    demux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load1),
        .load_data (in_data),
        .load_last (in_last),
        .ready     (out1_ready),
        .valid     (out1_valid),
        .data      (out1_data),
        .last      (out1_last)
    );

`ifdef STREAM_DEMUX2_CNT_EN
    // counters wrap naturally at 2**CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (load0) cnt0 <= cnt0 + 1'b1;
            if (load1) cnt1 <= cnt1 + 1'b1;
        end
    end
`endif

endmodule
